// File: rtl/pwm.sv
// Motor-speed PWM: 4-bit duty code -> fixed 15-step period, high for `result` steps.
// Latency: a duty change is latched at the period wrap and appears on speed_motor one clock later.
// Backpressure: none; `result` is sampled continuously and used only at the wrap.
//
// Ports:
//   clk          system clock, rising-edge active
//   rstN         asynchronous active-low reset
//   result[3:0]  duty code 0..15 (0 = always low, 15 = always high)
//   speed_motor  registered PWM drive
module pwm #(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [3:0] result,
  output logic       speed_motor
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [3:0] CNT_MAX = 4'd14;

  logic [PW-1:0] pre;
  logic [3:0]    cnt;
  logic [3:0]    duty_q;
  logic          tick;

  // With PRESCALE == 1, PRE_MAX is 0 and pre never leaves 0, so tick is
  // permanently asserted without needing a separate code path.
  assign tick = (pre == PRE_MAX);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pre         <= '0;
      cnt         <= '0;
      duty_q      <= '0;
      speed_motor <= 1'b0;
    end else begin
      if (tick) begin
        pre <= '0;
      end else begin
        pre <= pre + PW'(1);
      end

      // The duty is only latched at the wrap, so a period is never cut short
      // or stretched by a mid-period code change.
      if (tick) begin
        if (cnt == CNT_MAX) begin
          cnt    <= '0;
          duty_q <= result;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end

      // cnt tops out at 14, so a duty of 15 keeps the output high forever.
      speed_motor <= (cnt < duty_q);
    end
  end

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: two instances (PRESCALE 1 and 4) against an arithmetic reference model.
// Latency: the model predicts the output after every clock edge; checks are taken 1 ns after the edge.
// Backpressure: none; stimulus is driven directly between clock edges.
module tb_pwm;

  logic       clk;
  logic       rstN;
  logic [3:0] res_a;
  logic [3:0] res_b;
  logic       sm_a;
  logic       sm_b;

  int ncmp;
  int nfail;

  // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
  // e: clock edges since reset release; d: duty in force; expv: predicted output.
  int   ps[2];
  int   e[2];
  int   d[2];
  logic expv[2];

  pwm #(.PRESCALE(1)) u_p1 (
    .clk(clk), .rstN(rstN), .result(res_a), .speed_motor(sm_a)
  );

  pwm #(.PRESCALE(4)) u_p4 (
    .clk(clk), .rstN(rstN), .result(res_b), .speed_motor(sm_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Period is 15*P clocks, wraps at edges that are multiples of 15*P after
  // release. The output after edge k shows whether the step index of the
  // previous cycle, floor((k-1)/P) mod 15, lies below the duty in force then.
  task automatic model_edge(input int i, input logic [3:0] r, input logic rel);
    if (!rel) begin
      e[i]    = 0;
      d[i]    = 0;
      expv[i] = 1'b0;
    end else begin
      e[i]++;
      expv[i] = ((((e[i] - 1) / ps[i]) % 15) < d[i]);
      if ((e[i] % (15 * ps[i])) == 0) d[i] = r;
    end
  endtask

  task automatic step();
    logic [3:0] r0;
    logic [3:0] r1;
    logic       rel;
    r0  = res_a;
    r1  = res_b;
    rel = rstN;
    @(posedge clk);
    model_edge(0, r0, rel);
    model_edge(1, r1, rel);
    #1;
    check("p1_cycle", sm_a, expv[0]);
    check("p4_cycle", sm_b, expv[1]);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic count_high(input int n, output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int k = 0; k < n; k++) begin
      step();
      ca += int'(sm_a);
      cb += int'(sm_b);
    end
  endtask

  task automatic timeout_fail(input string tag);
    ncmp++;
    nfail++;
    $error("FAIL %s: wait bound expired, condition never observed", tag);
  endtask

  initial begin
    int  ca;
    int  cb;
    int  lim;
    bit  found;

    ncmp  = 0;
    nfail = 0;
    ps[0] = 1;
    ps[1] = 4;
    e[0]  = 0; e[1] = 0;
    d[0]  = 0; d[1] = 0;
    expv[0] = 1'b0; expv[1] = 1'b0;

    // Reset hold with code 7: low throughout and for the first period after release.
    rstN  = 1'b0;
    res_a = 4'd7;
    res_b = 4'd7;
    #2;
    check("reset_p1", sm_a, 1'b0);
    check("reset_p4", sm_b, 1'b0);
    run(3);
    rstN = 1'b1;
    count_high(15, ca, cb);
    check_int("post_reset_low_p1", ca, 0);
    check_int("post_reset_low_p4", cb, 0);

    // Code 0: permanently low.
    res_a = 4'd0;
    res_b = 4'd0;
    run(70);
    count_high(50, ca, cb);
    check_int("code0_p1", ca, 0);
    check_int("code0_p4", cb, 0);

    // Code 15: permanently high once latched.
    res_a = 4'd15;
    res_b = 4'd15;
    run(70);
    count_high(60, ca, cb);
    check_int("code15_p1", ca, 60);
    check_int("code15_p4", cb, 60);

    // Code 5: any full-period window holds exactly 5 steps high.
    res_a = 4'd5;
    res_b = 4'd5;
    run(70);
    count_high(15, ca, cb);
    check_int("code5_p1_highs", ca, 5);
    count_high(60, ca, cb);
    check_int("code5_p4_highs", cb, 20);

    // Mid-period change 5 -> 12 at step 3 on the PRESCALE 1 instance.
    found = 0;
    for (lim = 0; lim < 20 && !found; lim++) begin
      if ((e[0] % 15) == 3) found = 1;
      else step();
    end
    if (!found) timeout_fail("mid_change_align");
    res_a = 4'd12;
    found = 0;
    for (lim = 0; lim < 20 && !found; lim++) begin
      step();
      if ((e[0] % 15) == 0) found = 1;
    end
    if (!found) timeout_fail("mid_change_wrap");
    count_high(15, ca, cb);
    check_int("mid_change_next_period_p1", ca, 12);

    // Asynchronous reset mid-pulse with code 9.
    res_a = 4'd9;
    res_b = 4'd9;
    found = 0;
    for (lim = 0; lim < 40 && !found; lim++) begin
      step();
      if (sm_a === 1'b1) found = 1;
    end
    if (!found) timeout_fail("code9_pulse");
    #2;
    rstN = 1'b0;
    #1;
    check("async_reset_p1", sm_a, 1'b0);
    check("async_reset_p4", sm_b, 1'b0);
    run(3);
    rstN = 1'b1;

    // Code 5 again on the prescaled instance after the restart.
    res_a = 4'd5;
    res_b = 4'd5;
    run(130);
    count_high(60, ca, cb);
    check_int("code5_again_p1_highs", ca, 20);
    check_int("code5_again_p4_highs", cb, 20);

    // Randomised codes, hold times and occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      res_a = 4'($urandom_range(0, 15));
      res_b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        rstN = 1'b0;
        run(2);
        rstN = 1'b1;
      end
      run($urandom_range(1, 70));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
